// File: rtl/arith_pkg.sv
// Shared definitions for the iterative (digit-serial) arithmetic blocks.
package arith_pkg;

  // Sequencer states shared by the iterative blocks.
  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // Number of 2-bit digits in an operand of the given width.
  function automatic int unsigned num_digits(input int unsigned width);
    return width / 2;
  endfunction

  // Digit counter width: clog2(digits), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned nd;
    nd = width / 2;
    return (nd <= 1) ? 1 : $clog2(nd);
  endfunction

endpackage

// File: rtl/comp_2.sv
// 2-bit unsigned magnitude comparator used as one digit stage.
module comp_2 (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic       L,
  output logic       E,
  output logic       G
);

  assign L = (A < B);
  assign E = (A == B);
  assign G = (A > B);

endmodule

// File: rtl/serial_mag_comp.sv
// Digit-serial unsigned magnitude comparator: MSB-first, one 2-bit digit per clock,
// stopping at the first unequal digit. WIDTH must be even and at least 2.
module serial_mag_comp
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             G
);

  localparam int unsigned ND   = num_digits(WIDTH);
  localparam int unsigned CntW = cnt_width(WIDTH);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sa_d;
  logic [WIDTH-1:0]  sb_q, sb_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              l_q, l_d;
  logic              e_q, e_d;
  logic              g_q, g_d;
  logic              dig_l, dig_e, dig_g;

  // Digit stage always looks at the current top digit of the shift registers.
  comp_2 u_comp_2 (
    .A (sa_q[WIDTH-1 -: 2]),
    .B (sb_q[WIDTH-1 -: 2]),
    .L (dig_l),
    .E (dig_e),
    .G (dig_g)
  );

  // Next-state: operand load, digit shift/count, and result capture.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    e_d     = e_q;
    g_d     = g_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sa_d    = A;
          sb_d    = B;
          cnt_d   = CntW'(ND - 1);
          state_d = StRun;
        end
      end
      StRun: begin
        if (!dig_e || (cnt_q == '0)) begin
          l_d     = dig_l;
          e_d     = dig_e;
          g_d     = dig_g;
          state_d = StDone;
        end else begin
          sa_d  = sa_q << 2;
          sb_d  = sb_q << 2;
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        // The DONE->IDLE edge can already accept a new operation back-to-back.
        if (start) begin
          sa_d    = A;
          sb_d    = B;
          cnt_d   = CntW'(ND - 1);
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      e_q     <= e_d;
      g_q     <= g_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign L    = l_q;
  assign E    = e_q;
  assign G    = g_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp at WIDTH=8, 4 and 2.
module tb_serial_mag_comp;

  localparam int Timeout = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0, start4 = 1'b0, start2 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [1:0] a2 = '0, b2 = '0;
  logic busy8, done8, l8, e8, g8;
  logic busy4, done4, l4, e4, g4;
  logic busy2, done2, l2, e2, g2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_mag_comp #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .L(l8), .E(e8), .G(g8)
  );
  serial_mag_comp #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .L(l4), .E(e4), .G(g4)
  );
  serial_mag_comp #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2),
    .busy(busy2), .done(done2), .L(l2), .E(e2), .G(g2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         leg;  // {L,E,G}
    int         lat;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: edge on which done appears = 1-based index of first differing digit, else ND.
  function automatic int exp_lat(input int unsigned a, input int unsigned b, input int w);
    int nd;
    nd = w / 2;
    for (int i = 1; i <= nd; i++) begin
      if (((a >> (w - 2 * i)) & 3) != ((b >> (w - 2 * i)) & 3)) return i;
    end
    return nd;
  endfunction

  function automatic int exp_leg(input int unsigned a, input int unsigned b);
    return {29'd0, a < b, a == b, a > b};
  endfunction

  // One WIDTH=8 operation with a single-cycle start pulse.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int leg, input int lat,
                      input string nm);
    int n;
    logic busy_ok;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    busy_ok = busy8;
    n = 0;
    while (!done8 && n < Timeout) begin
      @(posedge clk); #1;
      n++;
      busy_ok = busy_ok & busy8;
    end
    chk({nm, "_lat"}, n, lat);
    chk({nm, "_leg"}, {29'd0, l8, e8, g8}, leg);
    chk({nm, "_busy_held"}, busy_ok, 1);
    @(posedge clk); #1;
    chk({nm, "_busy_fall"}, {30'd0, busy8, done8}, 0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 3'b010, 4};
    vecs[1] = '{8'h80, 8'h7F, 3'b001, 1};
    vecs[2] = '{8'h12, 8'h13, 3'b100, 4};
    vecs[3] = '{8'h40, 8'h90, 3'b100, 1};
    vecs[4] = '{8'h00, 8'h00, 3'b010, 4};
    vecs[5] = '{8'hFF, 8'h00, 3'b001, 1};
    vecs[6] = '{8'h0F, 8'h0E, 3'b001, 4};
    vecs[7] = '{8'h3C, 8'h3D, 3'b100, 4};
    vecs[8] = '{8'hC4, 8'hC8, 3'b100, 3};
    vecs[9] = '{8'h30, 8'h20, 3'b001, 2};

    // Reset state.
    #2;
    chk("rst8", {27'd0, busy8, done8, l8, e8, g8}, 0);
    chk("rst4", {27'd0, busy4, done4, l4, e4, g4}, 0);
    chk("rst2", {27'd0, busy2, done2, l2, e2, g2}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed table.
    foreach (vecs[i]) run8(vecs[i].a, vecs[i].b, vecs[i].leg, vecs[i].lat, $sformatf("vec%0d", i));

    // Start held high with A/B changing during RUN; back-to-back op accepted on DONE->IDLE edge.
    @(negedge clk);
    a8 = 8'h30; b8 = 8'h20; start8 = 1'b1;
    @(posedge clk); #1;                 // edge 0
    @(negedge clk); a8 = 8'h00; b8 = 8'hFF;
    @(posedge clk); #1;                 // edge 1
    chk("hold_e1_done", done8, 0);
    @(posedge clk); #1;                 // edge 2
    chk("hold_e2_done", done8, 1);
    chk("hold_e2_leg", {29'd0, l8, e8, g8}, 3'b001);
    @(negedge clk); a8 = 8'h01; b8 = 8'hFF;
    @(posedge clk); #1;                 // edge 3 accepts 01 vs FF
    start8 = 1'b0;
    chk("hold_e3", {30'd0, busy8, done8}, 2'b10);
    @(posedge clk); #1;                 // edge 4
    chk("hold_e4_done", done8, 1);
    chk("hold_e4_leg", {29'd0, l8, e8, g8}, 3'b100);
    begin
      int extra = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        extra += int'(done8);
      end
      chk("hold_single_done", extra, 0);
      chk("hold_idle", busy8, 0);
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;  // edge 0
    @(posedge clk); #1;                 // edge 1
    @(posedge clk); #2;                 // edge 2
    rst = 1'b1;
    #1;
    chk("midrst_out", {27'd0, busy8, done8, l8, e8, g8}, 0);
    @(negedge clk); rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        seen += int'(done8) + int'(busy8);
      end
      chk("midrst_no_done", seen, 0);
    end
    run8(8'h00, 8'h01, 3'b100, 4, "post_rst");

    // Randomized ops against the reference model; half share leading digits.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 2 == 0) rb = ra ^ (8'($urandom_range(0, 3)) << (2 * $urandom_range(0, 3)));
      run8(ra, rb, exp_leg(ra, rb), exp_lat(ra, rb, 8), $sformatf("rnd%0d", i));
    end

    // WIDTH=4 exhaustive sweep.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        int n;
        @(negedge clk);
        a4 = 4'(ia); b4 = 4'(ib); start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        n = 0;
        while (!done4 && n < Timeout) begin
          @(posedge clk); #1;
          n++;
        end
        chk($sformatf("w4_lat_%0d_%0d", ia, ib), n, exp_lat(ia, ib, 4));
        chk($sformatf("w4_leg_%0d_%0d", ia, ib), {29'd0, l4, e4, g4}, exp_leg(ia, ib));
        @(posedge clk); #1;
      end
    end

    // WIDTH=2: single digit, result must equal a plain 2-bit compare after edge 1.
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        int n;
        @(negedge clk);
        a2 = 2'(ia); b2 = 2'(ib); start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        n = 0;
        while (!done2 && n < Timeout) begin
          @(posedge clk); #1;
          n++;
        end
        chk($sformatf("w2_lat_%0d_%0d", ia, ib), n, 1);
        chk($sformatf("w2_leg_%0d_%0d", ia, ib), {29'd0, l2, e2, g2}, exp_leg(ia, ib));
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
